// File: rtl/clock_generation_multi_if.sv
// Configuration write port of clock_generation_multi: valid/ready write request
// carrying one channel's divisor, phase and start delay, plus a one-cycle reject pulse.
interface clock_generation_multi_if #(
    parameter int DIV_WIDTH    = 16,
    parameter int CH_SEL_WIDTH = 2
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [CH_SEL_WIDTH-1:0] cfg_channel;
    logic [DIV_WIDTH-1:0]    cfg_divisor;
    logic [DIV_WIDTH-1:0]    cfg_phase;
    logic [DIV_WIDTH-1:0]    cfg_delay;
    logic                    cfg_err;

    modport master (
        output cfg_valid, cfg_channel, cfg_divisor, cfg_phase, cfg_delay,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_channel, cfg_divisor, cfg_phase, cfg_delay,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clock_generation_multi.sv
// Multi-channel clock divider with per-channel divisor, start delay and phase offset,
// rising-edge strobes, and reconfiguration/stop that only take effect at period boundaries.
module clock_generation_multi #(
    parameter int NUM_CHANNELS = 4,
    parameter int DIV_WIDTH    = 16,
    parameter int DEFAULT_DIV  = 4,
    parameter int CH_SEL_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    clock_generation_multi_if.slave cfg,
    input  logic [NUM_CHANNELS-1:0] ch_en,
    output logic [NUM_CHANNELS-1:0] clk_out,
    output logic [NUM_CHANNELS-1:0] tick,
    output logic [NUM_CHANNELS-1:0] running
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PHASE = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ZERO    = DIV_WIDTH'(0);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);

    // Odd divisors put the extra cycle in the low half.
    function automatic logic [DIV_WIDTH-1:0] low_len(input logic [DIV_WIDTH-1:0] d);
        return d - (d >> 1'b1);
    endfunction

    function automatic logic [DIV_WIDTH-1:0] high_len(input logic [DIV_WIDTH-1:0] d);
        return d >> 1'b1;
    endfunction

    function automatic logic fields_ok(input logic [DIV_WIDTH-1:0] d,
                                       input logic [DIV_WIDTH-1:0] p);
        return (d >= TWO) && (p < d);
    endfunction

    logic cfg_ready_r;
    logic cfg_err_r;
    logic accept_s;
    logic cfg_bad_s;

    // Classify the write request presented this cycle.
    always_comb begin
        accept_s  = cfg.cfg_valid & cfg_ready_r;
        cfg_bad_s = ~fields_ok(cfg.cfg_divisor, cfg.cfg_phase)
                    | (32'(cfg.cfg_channel) >= 32'(NUM_CHANNELS));
    end

    // Configuration port handshake and reject pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready_r <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_ready_r <= 1'b1;
            cfg_err_r   <= accept_s & cfg_bad_s;
        end
    end

    assign cfg.cfg_ready = cfg_ready_r;
    assign cfg.cfg_err   = cfg_err_r;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        state_t               state_r;
        logic [DIV_WIDTH-1:0] cnt_r;
        logic                 hi_r;
        logic [DIV_WIDTH-1:0] sh_div_r;
        logic [DIV_WIDTH-1:0] sh_ph_r;
        logic [DIV_WIDTH-1:0] sh_dly_r;
        logic [DIV_WIDTH-1:0] act_div_r;
        logic [DIV_WIDTH-1:0] act_ph_r;
        logic [DIV_WIDTH-1:0] act_dly_r;
        logic [DIV_WIDTH-1:0] nx_div_s;
        logic [DIV_WIDTH-1:0] nx_ph_s;
        logic [DIV_WIDTH-1:0] nx_dly_s;
        logic                 wr_hit_s;
        logic                 boundary_s;
        logic                 clk_int_s;
        logic                 clk_out_r;
        logic                 tick_r;
        logic                 running_r;

        // Shadow config including a write landing this cycle, so it wins at a coincident start or boundary.
        always_comb begin
            wr_hit_s = accept_s & ~cfg_bad_s & (cfg.cfg_channel == CH_SEL_WIDTH'(gi));
            if (wr_hit_s) begin
                nx_div_s = cfg.cfg_divisor;
                nx_ph_s  = cfg.cfg_phase;
                nx_dly_s = cfg.cfg_delay;
            end else begin
                nx_div_s = sh_div_r;
                nx_ph_s  = sh_ph_r;
                nx_dly_s = sh_dly_r;
            end
            clk_int_s  = (state_r == ST_RUN) & hi_r;
            boundary_s = clk_int_s & (cnt_r == (high_len(act_div_r) - ONE));
        end

        // Channel sequencer: IDLE -> DELAY -> PHASE -> RUN (low half, high half, repeat).
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_r   <= ST_IDLE;
                cnt_r     <= ZERO;
                hi_r      <= 1'b0;
                sh_div_r  <= RST_DIV;
                sh_ph_r   <= ZERO;
                sh_dly_r  <= ZERO;
                act_div_r <= RST_DIV;
                act_ph_r  <= ZERO;
                act_dly_r <= ZERO;
                clk_out_r <= 1'b0;
                tick_r    <= 1'b0;
                running_r <= 1'b0;
            end else begin
                sh_div_r  <= nx_div_s;
                sh_ph_r   <= nx_ph_s;
                sh_dly_r  <= nx_dly_s;
                clk_out_r <= clk_int_s;
                tick_r    <= clk_int_s & ~clk_out_r;
                running_r <= (state_r != ST_IDLE);
                case (state_r)
                    ST_IDLE: begin
                        act_div_r <= nx_div_s;
                        act_ph_r  <= nx_ph_s;
                        act_dly_r <= nx_dly_s;
                        cnt_r     <= ZERO;
                        hi_r      <= 1'b0;
                        if (!ch_en[gi]) begin
                            state_r <= ST_IDLE;
                        end else if (nx_dly_s != ZERO) begin
                            state_r <= ST_DELAY;
                        end else if (nx_ph_s != ZERO) begin
                            state_r <= ST_PHASE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_DELAY: begin
                        if (!ch_en[gi]) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= ZERO;
                        end else if (cnt_r == (act_dly_r - ONE)) begin
                            cnt_r <= ZERO;
                            if (act_ph_r != ZERO) begin
                                state_r <= ST_PHASE;
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end else begin
                            cnt_r <= cnt_r + ONE;
                        end
                    end
                    ST_PHASE: begin
                        if (!ch_en[gi]) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= ZERO;
                        end else if (cnt_r == (act_ph_r - ONE)) begin
                            cnt_r   <= ZERO;
                            state_r <= ST_RUN;
                        end else begin
                            cnt_r <= cnt_r + ONE;
                        end
                    end
                    ST_RUN: begin
                        if (!hi_r) begin
                            if (cnt_r == (low_len(act_div_r) - ONE)) begin
                                hi_r  <= 1'b1;
                                cnt_r <= ZERO;
                            end else begin
                                cnt_r <= cnt_r + ONE;
                            end
                        end else if (boundary_s) begin
                            // Period boundary: only here may config change or the channel stop.
                            hi_r      <= 1'b0;
                            cnt_r     <= ZERO;
                            act_div_r <= nx_div_s;
                            act_ph_r  <= nx_ph_s;
                            act_dly_r <= nx_dly_s;
                            if (ch_en[gi]) begin
                                state_r <= ST_RUN;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + ONE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= ZERO;
                        hi_r    <= 1'b0;
                    end
                endcase
            end
        end

        assign clk_out[gi] = clk_out_r;
        assign tick[gi]    = tick_r;
        assign running[gi] = running_r;
    end

endmodule
